cmp_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered `Comparator` instance (N-bit, 1-cycle latency) among R requesters. Each requester submits an operand pair through a valid/ready handshake. The block serialises the operations through the comparator and returns the GT/LT/EQ result tagged with the requester ID through a valid/ready response port. It sits between the client blocks and the comparator datapath, and is the only driver of the comparator's inputs.

---
 rtl/cmp_arb_pkg.sv | 16 +
 rtl/Comparator.sv | 27 ++
 rtl/cmp_rr_pick.sv | 33 +++
 rtl/cmp_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// rtl/cmp_arb_pkg.sv - shared FSM encoding and ID-width helper for the comparator arbiter
package cmp_arb_pkg;

  // Sequencer states; encodings are fixed so they stay stable across users of the package
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Requester-ID width; never below one bit so ID ports always exist
  function automatic int calc_idw(input int r);
    return (r < 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/Comparator.sv
// rtl/Comparator.sv - registered unsigned N-bit comparator with one-cycle latency
module Comparator #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         GT,
  output logic         LT,
  output logic         EQ
);

  // Register the three relations every cycle; exactly one is set once out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      GT <= 1'b0;
      LT <= 1'b0;
      EQ <= 1'b0;
    end else begin
      GT <= (A > B);
      LT <= (A < B);
      EQ <= (A == B);
    end
  end

endmodule

// File: rtl/cmp_rr_pick.sv
// rtl/cmp_rr_pick.sv - combinational round-robin picker starting after the last grant
module cmp_rr_pick
  import cmp_arb_pkg::*;
#(
  parameter  int R   = 4,
  localparam int IDW = calc_idw(R)
) (
  input  logic [R-1:0]   req_valid,
  input  logic [IDW-1:0] last_grant,
  output logic [R-1:0]   grant_onehot,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Scan from last_grant+1 with wrap-around; the just-served requester is checked last
  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    any          = 1'b0;
    idx          = '0;
    for (int k = 1; k <= R; k++) begin
      idx = IDW'((int'(last_grant) + k) % R);
      if (!any && req_valid[idx]) begin
        any               = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_id          = idx;
      end
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin sequencer sharing one registered comparator among R requesters
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int R   = 4,
  localparam int IDW = calc_idw(R)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [IDW-1:0] resp_id,
  output logic           resp_gt,
  output logic           resp_lt,
  output logic           resp_eq,
  output logic           busy
);

  arb_state_t     state;
  logic [IDW-1:0] last_grant;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [IDW-1:0] op_id;

  logic [R-1:0]   pick_onehot;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           cmp_gt;
  logic           cmp_lt;
  logic           cmp_eq;

  cmp_rr_pick #(.R(R)) u_pick (
    .req_valid    (req_valid),
    .last_grant   (last_grant),
    .grant_onehot (pick_onehot),
    .grant_id     (pick_id),
    .any          (pick_any)
  );

  // op_a/op_b are the only drivers of the comparator; holding them keeps its output stable in DONE
  Comparator #(.N(N)) u_cmp (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (op_a),
    .B       (op_b),
    .GT      (cmp_gt),
    .LT      (cmp_lt),
    .EQ      (cmp_eq)
  );

  // Grant only while idle; reset also forces it low so nothing looks accepted during reset
  always_comb begin
    req_ready = '0;
    if (reset_n && (state == ST_IDLE)) req_ready = pick_onehot;
  end

  // Flags are only meaningful with a pending response
  assign resp_gt = resp_valid & cmp_gt;
  assign resp_lt = resp_valid & cmp_lt;
  assign resp_eq = resp_valid & cmp_eq;

  // Sequencer: accept in IDLE, let the comparator register in CMP, hold the response in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(R - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            op_a       <= req_a[pick_id*N +: N];
            op_b       <= req_b[pick_id*N +: N];
            op_id      <= pick_id;
            last_grant <= pick_id;
            busy       <= 1'b1;
            state      <= ST_CMP;
          end
        end
        ST_CMP: begin
          resp_valid <= 1'b1;
          resp_id    <= op_id;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
